// File: rtl/sonar_scan_scheduler.sv
// Round-robin ping scheduler: shares one trigger/echo measurement engine across
// NUM_SENSORS ultrasonic sensors and emits one tagged distance result per ping.
module sonar_scan_scheduler #(
    parameter int unsigned NUM_SENSORS  = 4,
    parameter int unsigned TRIG_CYCLES  = 500,
    parameter int unsigned ECHO_TIMEOUT = 1_500_000,
    parameter int unsigned GUARD_CYCLES = 50_000,
    parameter int unsigned CYC_PER_CM   = 2900
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_enable,
    input  logic [NUM_SENSORS-1:0]         i_sensor_mask,
    input  logic [NUM_SENSORS-1:0]         i_echo,
    output logic [NUM_SENSORS-1:0]         o_trig,
    output logic                           o_busy,
    output logic                           o_result_valid,
    output logic [$clog2(NUM_SENSORS)-1:0] o_result_id,
    output logic [15:0]                    o_result_cm,
    output logic                           o_result_timeout,
    output logic                           o_scan_done
);

    localparam int          N       = int'(NUM_SENSORS);
    localparam int unsigned IdW     = $clog2(NUM_SENSORS);
    localparam int unsigned MaxTg   = (TRIG_CYCLES > GUARD_CYCLES) ? TRIG_CYCLES : GUARD_CYCLES;
    localparam int unsigned MaxCnt  = (ECHO_TIMEOUT > MaxTg) ? ECHO_TIMEOUT : MaxTg;
    localparam int unsigned CntW    = $clog2(MaxCnt + 1);
    localparam int unsigned SubW    = $clog2(CYC_PER_CM);

    typedef enum logic [2:0] {StIdle, StTrig, StWaitRise, StMeasure, StGuard} state_e;

    state_e                 r_state, w_state_nxt;
    logic [N-1:0]           r_echo_s1, r_echo_s2;
    logic                   r_echo_prev;
    logic [IdW-1:0]         r_ptr, w_ptr_nxt;
    logic [IdW-1:0]         r_sel, w_sel_nxt;
    logic [CntW-1:0]        r_cnt, w_cnt_nxt;
    logic [SubW-1:0]        r_sub, w_sub_nxt;
    logic [15:0]            r_cm, w_cm_nxt;
    logic [N-1:0]           r_trig, w_trig_nxt;
    logic                   r_res_valid, w_res_valid_nxt;
    logic [IdW-1:0]         r_res_id, w_res_id_nxt;
    logic [15:0]            r_res_cm, w_res_cm_nxt;
    logic                   r_res_tmo, w_res_tmo_nxt;
    logic                   r_scan_done, w_scan_done_nxt;

    logic                   w_echo;
    logic                   w_found;
    logic [IdW-1:0]         w_pick;
    int                     w_idx;
    logic                   w_above;
    logic                   w_finish;
    logic                   w_fin_tmo;
    logic                   w_timeout;

    assign w_echo    = r_echo_s2[r_sel];
    assign w_timeout = (r_cnt == CntW'(ECHO_TIMEOUT - 1));

    // First enabled sensor at or after the pointer, wrapping around.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < N; i++) begin
            w_idx = (int'(r_ptr) + i) % N;
            if (!w_found && i_sensor_mask[w_idx]) begin
                w_pick  = IdW'(w_idx);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_above = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i > int'(r_sel) && i_sensor_mask[i]) w_above = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sel_nxt       = r_sel;
        w_ptr_nxt       = r_ptr;
        w_cnt_nxt       = r_cnt;
        w_sub_nxt       = r_sub;
        w_cm_nxt        = r_cm;
        w_res_valid_nxt = 1'b0;
        w_scan_done_nxt = 1'b0;
        w_res_id_nxt    = r_res_id;
        w_res_cm_nxt    = r_res_cm;
        w_res_tmo_nxt   = r_res_tmo;
        w_finish        = 1'b0;
        w_fin_tmo       = 1'b0;
        w_trig_nxt      = '0;

        unique case (r_state)
            StIdle: begin
                if (i_enable && w_found) begin
                    w_sel_nxt   = w_pick;
                    w_cnt_nxt   = '0;
                    w_state_nxt = StTrig;
                end
            end
            StTrig: begin
                if (r_cnt == CntW'(TRIG_CYCLES - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = StWaitRise;
                end else begin
                    w_cnt_nxt = r_cnt + CntW'(1);
                end
            end
            StWaitRise: begin
                w_cnt_nxt = r_cnt + CntW'(1);
                if (w_timeout) begin
                    w_finish  = 1'b1;
                    w_fin_tmo = 1'b1;
                end else if (w_echo && !r_echo_prev) begin
                    // The rise cycle is itself one high cycle of the echo.
                    w_sub_nxt   = SubW'(1);
                    w_cm_nxt    = '0;
                    w_state_nxt = StMeasure;
                end
            end
            StMeasure: begin
                w_cnt_nxt = r_cnt + CntW'(1);
                if (!w_echo) begin
                    w_finish = 1'b1;
                end else if (w_timeout) begin
                    w_finish  = 1'b1;
                    w_fin_tmo = 1'b1;
                end else if (r_sub == SubW'(CYC_PER_CM - 1)) begin
                    w_sub_nxt = '0;
                    if (r_cm != 16'hFFFF) w_cm_nxt = r_cm + 16'd1;
                end else begin
                    w_sub_nxt = r_sub + SubW'(1);
                end
            end
            StGuard: begin
                if (r_cnt == CntW'(GUARD_CYCLES - 1)) begin
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = (r_sel == IdW'(N - 1)) ? '0 : r_sel + IdW'(1);
                    w_state_nxt = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt + CntW'(1);
                end
            end
            default: w_state_nxt = StIdle;
        endcase

        if (w_finish) begin
            w_state_nxt     = StGuard;
            w_cnt_nxt       = '0;
            w_res_valid_nxt = 1'b1;
            w_res_id_nxt    = r_sel;
            w_res_cm_nxt    = w_fin_tmo ? 16'hFFFF : r_cm;
            w_res_tmo_nxt   = w_fin_tmo;
            w_scan_done_nxt = !w_above;
        end

        if (w_state_nxt == StTrig) w_trig_nxt[w_sel_nxt] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_echo_s1   <= '0;
            r_echo_s2   <= '0;
            r_echo_prev <= 1'b0;
            r_ptr       <= '0;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_sub       <= '0;
            r_cm        <= '0;
            r_trig      <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_cm    <= '0;
            r_res_tmo   <= 1'b0;
            r_scan_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_echo_s1   <= i_echo;
            r_echo_s2   <= r_echo_s1;
            r_echo_prev <= w_echo;
            r_ptr       <= w_ptr_nxt;
            r_sel       <= w_sel_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sub       <= w_sub_nxt;
            r_cm        <= w_cm_nxt;
            r_trig      <= w_trig_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_id    <= w_res_id_nxt;
            r_res_cm    <= w_res_cm_nxt;
            r_res_tmo   <= w_res_tmo_nxt;
            r_scan_done <= w_scan_done_nxt;
        end
    end

    assign o_trig           = r_trig;
    assign o_busy           = (r_state != StIdle);
    assign o_result_valid   = r_res_valid;
    assign o_result_id      = r_res_id;
    assign o_result_cm      = r_res_cm;
    assign o_result_timeout = r_res_tmo;
    assign o_scan_done      = r_scan_done;

endmodule

// File: tb/tb_sonar_scan_scheduler.sv
// Randomized bench for sonar_scan_scheduler with scaled-down timing parameters;
// a round-robin/echo-width reference model predicts every result.
module tb_sonar_scan_scheduler;

    localparam int N     = 4;
    localparam int IW    = $clog2(N);
    localparam int TRIG  = 5;
    localparam int TMO   = 300;
    localparam int GUARD = 20;
    localparam int CPC   = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [N-1:0]  mask = '0;
    logic [N-1:0]  echo = '0;
    logic [N-1:0]  trig;
    logic          busy;
    logic          rv;
    logic [IW-1:0] rid;
    logic [15:0]   rcm;
    logic          rtmo;
    logic          sdone;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_now = 0;
    int ptr_m = 0;
    int t_last_valid = 0;
    bit gap_valid = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_now <= cyc_now + 1;

    sonar_scan_scheduler #(
        .NUM_SENSORS (N),
        .TRIG_CYCLES (TRIG),
        .ECHO_TIMEOUT(TMO),
        .GUARD_CYCLES(GUARD),
        .CYC_PER_CM  (CPC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_enable        (enable),
        .i_sensor_mask   (mask),
        .i_echo          (echo),
        .o_trig          (trig),
        .o_busy          (busy),
        .o_result_valid  (rv),
        .o_result_id     (rid),
        .o_result_cm     (rcm),
        .o_result_timeout(rtmo),
        .o_scan_done     (sdone)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int i = 0; i < N; i++) begin
            if (m[(p + i) % N]) return (p + i) % N;
        end
        return 0;
    endfunction

    function automatic bit last_in_pass(input logic [N-1:0] m, input int s);
        for (int i = s + 1; i < N; i++) begin
            if (m[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_trig();
        int c = 0;
        while (trig == '0 && c < GUARD + 60) begin
            tick();
            c++;
        end
    endtask

    // mode: 0 echo, 1 no echo, 2 echo stuck high from trigger, 3 echo plus distractor
    task automatic do_ping(input int mode, input int d, input int w, input bit drop_en);
        int exp_id, wcnt, t_fall, c, extra;
        logic [N-1:0] oh;
        exp_id = pick(mask, ptr_m);
        oh = '0;
        oh[exp_id] = 1'b1;
        extra = 0;
        wait_trig();
        check_eq("trig_sel", trig, oh);
        if (gap_valid) check_eq("guard_gap", cyc_now - t_last_valid, GUARD + 1);
        if (mode == 2) echo[exp_id] = 1'b1;
        wcnt = 0;
        while (trig == oh && wcnt < TRIG + 10) begin
            tick();
            wcnt++;
        end
        check_eq("trig_width", wcnt, TRIG);
        check_eq("trig_fall", trig, 0);
        t_fall = cyc_now;
        if (mode == 0 || mode == 3) begin
            if (mode == 3) begin
                echo[(exp_id + 1) % N] = 1'b1;
                repeat (3) tick();
                echo[(exp_id + 1) % N] = 1'b0;
                extra = 3;
            end
            repeat (d) tick();
            echo[exp_id] = 1'b1;
            if (drop_en) enable = 1'b0;
            repeat (w) tick();
            echo[exp_id] = 1'b0;
        end
        c = 0;
        while (!rv && c < TMO + 50) begin
            tick();
            c++;
        end
        check_eq("result_seen", rv, 1);
        check_eq("result_id", rid, exp_id);
        check_eq("result_scan_done", sdone, last_in_pass(mask, exp_id));
        if (mode == 1 || mode == 2) begin
            check_eq("result_tmo", rtmo, 1);
            check_eq("result_cm_tmo", rcm, 16'hFFFF);
            check_eq("tmo_latency", cyc_now - t_fall, TMO);
        end else begin
            check_eq("result_tmo", rtmo, 0);
            check_eq("result_cm", rcm, w / CPC);
            check_eq("echo_latency", cyc_now - t_fall, d + w + 3 + extra);
        end
        echo = '0;
        t_last_valid = cyc_now;
        gap_valid = 1'b1;
        ptr_m = (exp_id + 1) % N;
        tick();
        check_eq("strobe_len", rv, 0);
        check_eq("result_held", rid, exp_id);
    endtask

    initial begin
        int seen, c;
        repeat (3) tick();
        check_eq("rst_trig", trig, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", rv, 0);
        check_eq("rst_cm", rcm, 0);
        check_eq("rst_tmo", rtmo, 0);
        check_eq("rst_scan_done", sdone, 0);
        rst_n = 1'b1;
        tick();

        enable = 1'b1;
        mask = 4'b0001;
        do_ping(0, 4, 10 * CPC, 1'b0);
        do_ping(0, 2, CPC - 1, 1'b0);
        do_ping(0, 7, CPC, 1'b0);
        do_ping(1, 0, 0, 1'b0);
        do_ping(2, 0, 0, 1'b0);

        mask = 4'b0101;
        repeat (4) do_ping(0, $urandom_range(0, 20), $urandom_range(1, 150), 1'b0);

        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 2) == 0) mask = N'($urandom_range(1, (1 << N) - 1));
            do_ping(int'($urandom_range(0, 3)), int'($urandom_range(0, 30)),
                    int'($urandom_range(1, 200)), 1'b0);
        end

        // enable dropped mid-measurement: ping completes, then scheduler idles
        mask = 4'b0010;
        do_ping(0, 5, 40, 1'b1);
        seen = 0;
        repeat (3 * GUARD) begin
            tick();
            if (trig != '0) seen = 1;
        end
        check_eq("no_trig_after_disable", seen, 0);
        check_eq("idle_after_disable", busy, 0);

        // reset during trigger pulse
        enable = 1'b1;
        mask = 4'b1111;
        gap_valid = 1'b0;
        wait_trig();
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("rst_trig_drop", trig, 0);
        check_eq("rst_busy_drop", busy, 0);
        tick();
        rst_n = 1'b1;
        ptr_m = 0;
        do_ping(0, 3, 25, 1'b0);

        // reset mid-measurement
        gap_valid = 1'b0;
        wait_trig();
        c = 0;
        while (trig != '0 && c < TRIG + 10) begin
            tick();
            c++;
        end
        echo[ptr_m] = 1'b1;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check_eq("rst_meas_trig", trig, 0);
        check_eq("rst_meas_valid", rv, 0);
        check_eq("rst_meas_busy", busy, 0);
        check_eq("rst_meas_cm", rcm, 0);
        echo = '0;
        tick();
        rst_n = 1'b1;
        ptr_m = 0;
        do_ping(0, 1, 33, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
